// File: rtl/debounce_botoes_pkg.sv
// Shared constants for the stopwatch button conditioning stage.
//   IDX_CONTA / IDX_PAUSA / IDX_PARA : bit positions of each button in the
//                                      3-bit channel vectors ({para, pausa, conta}).
//   DEBOUNCE_50MHZ                   : 20 ms worth of 50 MHz clock cycles.
package debounce_botoes_pkg;

  localparam int NUM_BOTOES     = 3;
  localparam int IDX_CONTA      = 0;
  localparam int IDX_PAUSA      = 1;
  localparam int IDX_PARA       = 2;
  localparam int DEBOUNCE_50MHZ = 1000000;

  // Counter width able to hold 0 .. debounce-1.
  function automatic int cnt_width(input int debounce);
    return (debounce > 2) ? $clog2(debounce) : 1;
  endfunction

endpackage

// File: rtl/debounce_botoes_canal.sv
// One debounced button channel.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   n_in    : normalised raw button (1 = pressed), asynchronous to clk
//   estavel : debounced level (1 = pressed), resets to 1
//   pulso   : one-cycle registered pulse on an accepted 0->1 transition
module debounce_canal
  import debounce_botoes_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_50MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic n_in,
  output logic estavel,
  output logic pulso
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          estavel_reg;
  logic          pulso_reg;
  logic [CW-1:0] cnt_reg;

  // Everything resets to "pressed" so a button held through reset release
  // never looks like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      estavel_reg <= 1'b1;
      pulso_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= n_in;
      sync2_reg <= sync1_reg;
      pulso_reg <= 1'b0;
      if (sync2_reg == estavel_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        // DEBOUNCE-th consecutive mismatched sample: accept the new level.
        // sync2 differs from estavel here, so sync2 = 1 means a 0->1 change.
        estavel_reg <= sync2_reg;
        pulso_reg   <= sync2_reg;
        cnt_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign estavel = estavel_reg;
  assign pulso   = pulso_reg;

endmodule

// File: rtl/debounce_botoes.sv
// Button conditioning for the stopwatch FSM: normalises, synchronises and
// debounces the three raw buttons and issues at most one command pulse per
// cycle (priority para > pausa > conta; losers are dropped, not queued).
//   clk          : system clock (50 MHz)
//   reset        : asynchronous, active-low reset
//   btn_conta    : raw start button
//   btn_pausa    : raw pause button
//   btn_para     : raw stop button
//   conta_p      : one-cycle start command
//   pausa_p      : one-cycle pause command
//   para_p       : one-cycle stop command
//   pressionado  : debounced levels {para, pausa, conta}, 1 = pressed
module debounce_botoes
  import debounce_botoes_pkg::*;
#(
  parameter int DEBOUNCE    = DEBOUNCE_50MHZ,  // minimum 2
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_conta,
  input  logic       btn_pausa,
  input  logic       btn_para,
  output logic       conta_p,
  output logic       pausa_p,
  output logic       para_p,
  output logic [2:0] pressionado
);

  logic [NUM_BOTOES-1:0] raw;
  logic [NUM_BOTOES-1:0] n_norm;
  logic [NUM_BOTOES-1:0] estavel;
  logic [NUM_BOTOES-1:0] pulso;

  assign raw[IDX_CONTA] = btn_conta;
  assign raw[IDX_PAUSA] = btn_pausa;
  assign raw[IDX_PARA]  = btn_para;

  // n = 1 always means pressed, whatever the board polarity.
  assign n_norm = ATIVO_BAIXO ? ~raw : raw;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BOTOES; gi++) begin : g_canal
      debounce_canal #(
        .DEBOUNCE (DEBOUNCE)
      ) u_canal (
        .clk     (clk),
        .reset   (reset),
        .n_in    (n_norm[gi]),
        .estavel (estavel[gi]),
        .pulso   (pulso[gi])
      );
    end
  endgenerate

  // Fixed-priority arbiter over the registered channel pulses.
  always_comb begin
    para_p  = pulso[IDX_PARA];
    pausa_p = pulso[IDX_PAUSA] & ~pulso[IDX_PARA];
    conta_p = pulso[IDX_CONTA] & ~pulso[IDX_PAUSA] & ~pulso[IDX_PARA];
  end

  assign pressionado = estavel;

endmodule

// File: tb/tb_debounce_botoes.sv
module tb_debounce_botoes;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_conta = 1'b1;
  logic       btn_pausa = 1'b1;
  logic       btn_para  = 1'b1;
  logic       conta_p, pausa_p, para_p;
  logic [2:0] pressionado;

  debounce_botoes #(.DEBOUNCE(DEB), .ATIVO_BAIXO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .btn_conta(btn_conta), .btn_pausa(btn_pausa), .btn_para(btn_para),
    .conta_p(conta_p), .pausa_p(pausa_p), .para_p(para_p),
    .pressionado(pressionado)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int edge_no; } evt_t;
  typedef struct { logic [2:0] press; int hold; logic [2:0] lvl; int ch; } vec_t;

  evt_t exp_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_cnt, act, exp);
    end
  endtask

  // Scoreboard side: every observed pulse must match the next expected event.
  task automatic monitor();
    logic [2:0] p;
    int ch;
    evt_t e;
    p = {para_p, pausa_p, conta_p};
    if (reset && p != 3'b000) begin
      ch = p[2] ? 2 : (p[1] ? 1 : 0);
      checks++;
      if ($countones(p) != 1) begin
        errors++;
        $display("FAIL pulse_onehot edge %0d: got %b expected one pulse", edge_cnt, p);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected edge %0d: got ch %0d expected none", edge_cnt, ch);
      end else begin
        e = exp_q.pop_front();
        if (e.ch != ch || e.edge_no != edge_cnt) begin
          errors++;
          $display("FAIL pulse_match: got ch %0d at edge %0d expected ch %0d at edge %0d",
                   ch, edge_cnt, e.ch, e.edge_no);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [2:0] press);
    btn_conta = ~press[0];
    btn_pausa = ~press[1];
    btn_para  = ~press[2];
  endtask

  task automatic expect_pulse(input int ch);
    evt_t e;
    e.ch = ch;
    e.edge_no = edge_cnt + 1 + DEB + 1;  // press settles before edge edge_cnt+1
    exp_q.push_back(e);
  endtask

  task automatic chk_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending pulses expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{press: 3'b001, hold: 12, lvl: 3'b001, ch: 0};
    vecs[1] = '{press: 3'b100, hold: 3,  lvl: 3'b000, ch: -1};
    vecs[2] = '{press: 3'b101, hold: 10, lvl: 3'b101, ch: 2};
    vecs[3] = '{press: 3'b010, hold: 10, lvl: 3'b010, ch: 1};
    vecs[4] = '{press: 3'b111, hold: 10, lvl: 3'b111, ch: 2};
    vecs[5] = '{press: 3'b010, hold: 4,  lvl: 3'b010, ch: 1};

    // Reset state, then release with all buttons up.
    repeat (3) @(negedge clk);
    chk("reset_pulses", {para_p, pausa_p, conta_p}, 3'b000);
    chk("reset_level", pressionado, 3'b111);
    reset = 1'b1;
    edge_cnt = 0;
    for (int e = 1; e <= DEB + 2; e++) begin
      tick();
      chk("release_level", pressionado, (e < DEB + 2) ? 3'b111 : 3'b000);
    end
    ticks(4);

    // Table-driven presses.
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].press);
      if (vecs[v].ch >= 0) expect_pulse(vecs[v].ch);
      ticks(vecs[v].hold);
      drive(3'b000);
      ticks(2);
      chk($sformatf("vec%0d_level", v), pressionado, vecs[v].lvl);
      ticks(12);
      chk($sformatf("vec%0d_idle", v), pressionado, 3'b000);
      chk_drained($sformatf("vec%0d_drained", v));
      $display("vector %0d press=%b hold=%0d done at edge %0d", v, vecs[v].press, vecs[v].hold, edge_cnt);
    end

    // Bouncing pausa: toggles every 2 cycles, then settles pressed.
    for (int i = 0; i < 10; i++) begin
      drive(3'b010); ticks(2);
      drive(3'b000); ticks(2);
    end
    drive(3'b010);
    expect_pulse(1);
    ticks(12);
    chk("bounce_level", pressionado, 3'b010);
    drive(3'b000);
    ticks(12);
    chk_drained("bounce_drained");
    $display("bounce sequence done at edge %0d", edge_cnt);

    // Pausa held across a reset pulse: no pulse until re-pressed.
    drive(3'b010);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_pulses", {para_p, pausa_p, conta_p}, 3'b000);
    chk("async_reset_level", pressionado, 3'b111);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    edge_cnt = 0;
    ticks(20);
    chk("held_reset_level", pressionado, 3'b010);
    drive(3'b000);
    ticks(10);
    chk("held_release_level", pressionado, 3'b000);
    drive(3'b010);
    expect_pulse(1);
    ticks(10);
    drive(3'b000);
    ticks(12);
    chk_drained("held_repress_drained");
    $display("held-through-reset sequence done at edge %0d", edge_cnt);

    // Reset in the middle of a debounce count.
    drive(3'b001);
    ticks(3);
    #2 reset = 1'b0;
    #1;
    chk("midcount_pulses", {para_p, pausa_p, conta_p}, 3'b000);
    chk("midcount_level", pressionado, 3'b111);
    drive(3'b000);
    @(negedge clk);
    reset = 1'b1;
    edge_cnt = 0;
    ticks(12);
    chk("midcount_idle", pressionado, 3'b000);
    chk_drained("midcount_drained");
    $display("mid-count reset sequence done at edge %0d", edge_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
